// File: rtl/fixed_hardswish_pkg.sv
// Shared types and helpers for the fixed-point hardswish backward datapath.
package fixed_hardswish_pkg;

   // Which piece of the hardswish derivative a lane falls into.
   typedef enum logic [1:0] {
      ZERO = 2'd0,
      PASS = 2'd1,
      MID  = 2'd2
   } region_e;

   // The constant 3.0 expressed with f fractional bits.
   function automatic logic signed [63:0] three_of(input int f);
      return 64'sd3 <<< f;
   endfunction

   // Move a value from from_f to to_f fractional bits.
   // Dropping bits uses an arithmetic shift, so it rounds toward -inf.
   function automatic logic signed [63:0] realign(input logic signed [63:0] v,
                                                  input int from_f, input int to_f);
      if (to_f >= from_f) return v <<< (to_f - from_f);
      else                return v >>> (from_f - to_f);
   endfunction

   // Clamp to the range of a w-bit signed number instead of letting it wrap.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/fixed_hardswish_grad_lane.sv
// Per-lane region classification and slope for the hardswish derivative.
// The slope is (2x+3)/6 approximated as d/8 + d/16 with d = 2x+3.
module fixed_hardswish_grad_lane
   import fixed_hardswish_pkg::*;
#(
   parameter int W = 8,
   parameter int F = 4
) (
   input  logic [W-1:0] x,
   output region_e      region,
   output logic [W+1:0] slope
);

   localparam logic signed [W+1:0] THREE = (W+2)'(three_of(F));

   logic signed [W+1:0] xe;
   logic signed [W+1:0] d;

   // Classify x against +/-3 and, for the middle band, form the slope.
   always_comb begin
      xe     = (W+2)'($signed(x));
      d      = (xe <<< 1) + THREE;
      region = MID;
      slope  = '0;
      if (xe < -THREE)      region = ZERO;
      else if (xe >= THREE) region = PASS;
      else                  slope  = (d >>> 3) + (d >>> 4);
   end

endmodule

// File: rtl/fixed_mult.sv
// Full-width signed multiplier; the product keeps every bit of both operands.
module fixed_mult #(
   parameter int A_W = 8,
   parameter int B_W = 8
) (
   input  logic signed [A_W-1:0]     a,
   input  logic signed [B_W-1:0]     b,
   output logic signed [A_W+B_W-1:0] p
);

   assign p = (A_W+B_W)'(a) * (A_W+B_W)'(b);

endmodule

// File: rtl/fixed_hardswish_backward.sv
// Hardswish backward: joins saved x and upstream gradient g, emits
// g * hardswish'(x) per lane through a 2-stage registered pipeline.
module fixed_hardswish_backward
   import fixed_hardswish_pkg::*;
#(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 4,
   parameter int DATA_IN_1_PRECISION_0       = 8,
   parameter int DATA_IN_1_PRECISION_1       = 4,
   parameter int DATA_OUT_0_PRECISION_0      = 8,
   parameter int DATA_OUT_0_PRECISION_1      = 4,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
   localparam int P = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [P-1:0][DATA_IN_0_PRECISION_0-1:0]  data_in_0,
   input  logic                                     data_in_0_valid,
   output logic                                     data_in_0_ready,
   input  logic [P-1:0][DATA_IN_1_PRECISION_0-1:0]  data_in_1,
   input  logic                                     data_in_1_valid,
   output logic                                     data_in_1_ready,
   output logic [P-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
   output logic                                     data_out_0_valid,
   input  logic                                     data_out_0_ready
);

   localparam int W  = DATA_IN_0_PRECISION_0;
   localparam int F  = DATA_IN_0_PRECISION_1;
   localparam int GW = DATA_IN_1_PRECISION_0;
   localparam int GF = DATA_IN_1_PRECISION_1;
   localparam int OW = DATA_OUT_0_PRECISION_0;
   localparam int OF = DATA_OUT_0_PRECISION_1;
   localparam int SW = W + 2;
   localparam int PW = GW + SW;

   logic                         s1_valid_q, s1_valid_d;
   region_e [P-1:0]              s1_region_q, s1_region_d;
   logic    [P-1:0][SW-1:0]      s1_slope_q, s1_slope_d;
   logic    [P-1:0][GW-1:0]      s1_g_q, s1_g_d;
   logic                         s2_valid_q, s2_valid_d;
   logic    [P-1:0][OW-1:0]      s2_data_q, s2_data_d;

   region_e [P-1:0]              ln_region;
   logic    [P-1:0][SW-1:0]      ln_slope;
   logic    [P-1:0][PW-1:0]      prod;
   logic    [P-1:0][OW-1:0]      res;

   logic s1_ready, s2_ready, fire;

   for (genvar i = 0; i < P; i++) begin : g_lane
      logic signed [63:0] wide;

      fixed_hardswish_grad_lane #(.W(W), .F(F)) u_lane (
         .x      (data_in_0[i]),
         .region (ln_region[i]),
         .slope  (ln_slope[i])
      );

      fixed_mult #(.A_W(GW), .B_W(SW)) u_mult (
         .a (s1_g_q[i]),
         .b (s1_slope_q[i]),
         .p (prod[i])
      );

      // Stage-2 result: select by region, drop the slope's fraction, realign, clamp.
      always_comb begin
         wide = '0;
         case (s1_region_q[i])
            PASS:    wide = realign(64'($signed(s1_g_q[i])), GF, OF);
            MID:     wide = realign(64'($signed(prod[i])) >>> F, GF, OF);
            default: wide = '0;
         endcase
         res[i] = OW'(saturate(wide, OW));
      end
   end

   // Handshake, stage enables and next-state for both pipeline stages.
   always_comb begin
      s2_ready    = !s2_valid_q | data_out_0_ready;
      s1_ready    = !s1_valid_q | s2_ready;
      // No accept is reported while reset is held.
      fire        = data_in_0_valid & data_in_1_valid & s1_ready & !rst;
      s1_valid_d  = s1_valid_q;
      s1_region_d = s1_region_q;
      s1_slope_d  = s1_slope_q;
      s1_g_d      = s1_g_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      if (s1_ready) begin
         s1_valid_d = fire;
         if (fire) begin
            s1_region_d = ln_region;
            s1_slope_d  = ln_slope;
            s1_g_d      = data_in_1;
         end
      end
      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_data_d = res;
      end
   end

   // Pipeline registers; reset drops all in-flight beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         for (int i = 0; i < P; i++) s1_region_q[i] <= ZERO;
         s1_slope_q <= '0;
         s1_g_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_region_q <= s1_region_d;
         s1_slope_q  <= s1_slope_d;
         s1_g_q      <= s1_g_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
      end
   end

   assign data_in_0_ready  = fire;
   assign data_in_1_ready  = fire;
   assign data_out_0       = s2_data_q;
   assign data_out_0_valid = s2_valid_q;

endmodule

// File: tb/tb_fixed_hardswish_backward.sv
// Directed bench for fixed_hardswish_backward (W=8, F=4, P=1).
module tb_fixed_hardswish_backward;

   logic            clk = 1'b0;
   logic            rst;
   logic [0:0][7:0] data_in_0;
   logic            data_in_0_valid;
   logic            data_in_0_ready;
   logic [0:0][7:0] data_in_1;
   logic            data_in_1_valid;
   logic            data_in_1_ready;
   logic [0:0][7:0] data_out_0;
   logic            data_out_0_valid;
   logic            data_out_0_ready;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0]  sx [16];
   logic [7:0]  sg [16];
   logic [7:0]  se [16];
   logic [31:0] pat;
   int          in_idx;
   int          out_idx;

   fixed_hardswish_backward dut (
      .clk              (clk),
      .rst              (rst),
      .data_in_0        (data_in_0),
      .data_in_0_valid  (data_in_0_valid),
      .data_in_0_ready  (data_in_0_ready),
      .data_in_1        (data_in_1),
      .data_in_1_valid  (data_in_1_valid),
      .data_in_1_ready  (data_in_1_ready),
      .data_out_0       (data_out_0),
      .data_out_0_valid (data_out_0_valid),
      .data_out_0_ready (data_out_0_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One isolated beat: ready on offer, 2-cycle latency, one output only.
   task automatic single(input string tag, input logic [7:0] x, input logic [7:0] g,
                         input logic [7:0] e);
      @(negedge clk);
      data_in_0 = x; data_in_1 = g;
      data_in_0_valid = 1'b1; data_in_1_valid = 1'b1; data_out_0_ready = 1'b1;
      #1 chk({tag, "_rdy"}, 32'(data_in_0_ready), 32'h1);
      @(negedge clk);
      data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(data_out_0_valid), 32'h0);
      @(negedge clk);
      chk({tag, "_vld"}, 32'(data_out_0_valid), 32'h1);
      chk({tag, "_data"}, 32'(data_out_0), 32'(e));
      @(negedge clk);
      chk({tag, "_once"}, 32'(data_out_0_valid), 32'h0);
   endtask

   initial begin
      sx = '{8'h00, 8'h10, 8'hF0, 8'hE0, 8'hCF, 8'h40, 8'h7F, 8'h80,
             8'h08, 8'h01, 8'hD1, 8'h2F, 8'h20, 8'hF8, 8'h18, 8'h30};
      sg = '{8'h10, 8'h10, 8'h20, 8'h10, 8'h50, 8'h25, 8'h80, 8'h7F,
             8'hF0, 8'hFF, 8'h7F, 8'h80, 8'h10, 8'h30, 8'h08, 8'hC3};
      se = '{8'h09, 8'h0F, 8'h06, 8'hFD, 8'h00, 8'h25, 8'h80, 8'h00,
             8'hF4, 8'hFF, 8'hB8, 8'h80, 8'h15, 8'h12, 8'h09, 8'hC3};
      pat = 32'hB4D2_6A5C;

      // Reset with both valids high: nothing accepted, outputs cleared.
      rst = 1'b1;
      data_in_0 = 8'h00; data_in_1 = 8'h10;
      data_in_0_valid = 1'b1; data_in_1_valid = 1'b1; data_out_0_ready = 1'b1;
      #2;
      chk("rst_rdy0", 32'(data_in_0_ready), 32'h0);
      chk("rst_rdy1", 32'(data_in_1_ready), 32'h0);
      chk("rst_vld", 32'(data_out_0_valid), 32'h0);
      chk("rst_data", 32'(data_out_0), 32'h0);
      @(negedge clk);
      data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
      rst = 1'b0;

      // Directed single beats, including both region boundaries and saturation.
      single("x0", 8'h00, 8'h10, 8'h09);
      single("xm4", 8'hC0, 8'h10, 8'h00);
      single("xp3", 8'h30, 8'h10, 8'h10);
      single("xm3", 8'hD0, 8'h10, 8'hF7);
      single("sat", 8'h2F, 8'h7F, 8'h7F);

      // Lone valid on x only: never consumed.
      @(negedge clk);
      data_in_0 = 8'h10; data_in_1 = 8'h10;
      data_in_0_valid = 1'b1; data_in_1_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("lone_rdy0", 32'(data_in_0_ready), 32'h0);
         chk("lone_rdy1", 32'(data_in_1_ready), 32'h0);
         @(negedge clk);
         chk("lone_vld", 32'(data_out_0_valid), 32'h0);
      end
      data_in_1_valid = 1'b1;
      #1 chk("join_rdy", 32'(data_in_1_ready), 32'h1);
      @(negedge clk);
      data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
      @(negedge clk);
      chk("join_vld", 32'(data_out_0_valid), 32'h1);
      chk("join_data", 32'(data_out_0), 32'h0F);
      @(negedge clk);
      chk("join_once", 32'(data_out_0_valid), 32'h0);

      // Streaming with output ready toggling; held data is checked every valid cycle.
      in_idx = 0; out_idx = 0;
      for (int cyc = 0; cyc < 300 && out_idx < 16; cyc++) begin
         @(negedge clk);
         if (data_out_0_valid) chk("stream", 32'(data_out_0), 32'(se[out_idx]));
         data_out_0_ready = pat[cyc % 32];
         if (data_out_0_valid && data_out_0_ready) out_idx++;
         if (in_idx < 16) begin
            data_in_0 = sx[in_idx]; data_in_1 = sg[in_idx];
            data_in_0_valid = 1'b1; data_in_1_valid = 1'b1;
         end else begin
            data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
         end
         #1;
         if (data_in_0_ready) in_idx++;
      end
      chk("stream_count", 32'(out_idx), 32'd16);
      @(negedge clk);
      data_in_0_valid = 1'b0; data_in_1_valid = 1'b0; data_out_0_ready = 1'b1;
      @(negedge clk);
      chk("stream_tail", 32'(data_out_0_valid), 32'h0);

      // Fill both stages with output stalled, then drain and fire together.
      @(negedge clk);
      data_out_0_ready = 1'b0;
      data_in_0 = 8'h10; data_in_1 = 8'h10;
      data_in_0_valid = 1'b1; data_in_1_valid = 1'b1;
      #1 chk("fill_a_rdy", 32'(data_in_0_ready), 32'h1);
      @(negedge clk);
      data_in_0 = 8'hF0; data_in_1 = 8'h20;
      #1 chk("fill_b_rdy", 32'(data_in_0_ready), 32'h1);
      @(negedge clk);
      chk("full_vld", 32'(data_out_0_valid), 32'h1);
      chk("full_data", 32'(data_out_0), 32'h0F);
      data_in_0 = 8'hE0; data_in_1 = 8'h10;
      #1 chk("full_rdy0", 32'(data_in_0_ready), 32'h0);
      chk("full_rdy1", 32'(data_in_1_ready), 32'h0);
      @(negedge clk);
      chk("hold_data", 32'(data_out_0), 32'h0F);
      data_out_0_ready = 1'b1;
      #1 chk("drain_rdy", 32'(data_in_0_ready), 32'h1);
      @(negedge clk);
      data_in_0_valid = 1'b0; data_in_1_valid = 1'b0; data_out_0_ready = 1'b0;
      chk("drain_vld", 32'(data_out_0_valid), 32'h1);
      chk("drain_data", 32'(data_out_0), 32'h06);

      // Reset with two beats in flight: valid drops at once, nothing reappears.
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(data_out_0_valid), 32'h0);
      chk("mid_rst_data", 32'(data_out_0), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      data_out_0_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_vld", 32'(data_out_0_valid), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
